// File: rtl/axi4l_gpio_irq_if.sv
// AXI4-Lite register port bundle: 32-bit address and data on a single clock.
interface axi4l_if;
  logic        aclk;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  aclk, awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_gpio_irq.sv
// GPIO block with AXI4-Lite registers, synchronised and debounced inputs,
// edge-capturing STATUS and a registered level interrupt.
module axi4l_gpio_irq #(
  parameter int unsigned      Width      = 32,
  parameter int unsigned      SyncStages = 2,
  parameter int unsigned      Prescale   = 1,
  parameter logic [Width-1:0] RstOut     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  axi4l_if.slave           axi,
  input  logic [Width-1:0] gpio_i,
  output logic [Width-1:0] gpio_o,
  output logic [Width-1:0] gpio_en,
  output logic             irq
);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [15:0] TickCount  = 16'(Prescale - 1);
  localparam logic [3:0]  LastIdx    = 4'd8;

  logic             r_awready, r_bvalid, r_arready, r_rvalid, r_irq;
  logic [1:0]       r_bresp, r_rresp;
  logic [31:0]      r_rdata;
  logic [Width-1:0] r_data_out, r_dir, r_rise_en, r_fall_en, r_status, r_ie;
  logic [Width-1:0] r_sync [SyncStages];
  logic [Width-1:0] r_sample, r_deb;
  logic [15:0]      r_pcnt;

  logic             w_wr_hs, w_rd_hs, w_tick, w_unused;
  logic [3:0]       w_wr_idx, w_rd_idx;
  logic [8:0]       w_we;
  logic [31:0]      w_strb_mask, w_wbits;
  logic [Width-1:0] w_wmask, w_wval, w_sync, w_agree, w_deb_next;
  logic [Width-1:0] w_edge_set, w_status_next, w_data_out_next, w_rd_val;

  assign w_wr_hs  = r_awready & axi.awvalid & axi.wvalid;
  assign w_rd_hs  = r_arready & axi.arvalid;
  assign w_wr_idx = axi.awaddr[5:2];
  assign w_rd_idx = axi.araddr[5:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_strb
    assign w_strb_mask[8*gi +: 8] = {8{axi.wstrb[gi]}};
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_we
    assign w_we[gi] = w_wr_hs && (w_wr_idx == 4'(gi));
  end

  assign w_wbits = axi.wdata & w_strb_mask;
  assign w_wval  = w_wbits[Width-1:0];
  assign w_wmask = w_strb_mask[Width-1:0];

  // A debounced bit follows the input only once two consecutive tick samples agree.
  assign w_sync     = r_sync[SyncStages-1];
  assign w_tick     = (r_pcnt == TickCount);
  assign w_agree    = ~(w_sync ^ r_sample);
  assign w_deb_next = w_tick ? ((r_deb & ~w_agree) | (w_sync & w_agree)) : r_deb;
  assign w_edge_set = (w_deb_next & ~r_deb & r_rise_en) | (~w_deb_next & r_deb & r_fall_en);

  // Edge capture is ORed in after the W1C clear so a coincident set wins.
  assign w_status_next = (r_status & ~(w_we[5] ? w_wval : '0)) | w_edge_set;

  always_comb begin
    w_data_out_next = r_data_out;
    if (w_we[1])      w_data_out_next = (r_data_out & ~w_wmask) | w_wval;
    else if (w_we[7]) w_data_out_next = r_data_out | w_wval;
    else if (w_we[8]) w_data_out_next = r_data_out & ~w_wval;
  end

  always_comb begin
    w_rd_val = '0;
    case (w_rd_idx)
      4'd0:    w_rd_val = r_deb;
      4'd1:    w_rd_val = r_data_out;
      4'd2:    w_rd_val = r_dir;
      4'd3:    w_rd_val = r_rise_en;
      4'd4:    w_rd_val = r_fall_en;
      4'd5:    w_rd_val = r_status;
      4'd6:    w_rd_val = r_ie;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awready  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RespOkay;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RespOkay;
      r_rdata    <= '0;
      r_irq      <= 1'b0;
      r_data_out <= RstOut;
      r_dir      <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_status   <= '0;
      r_ie       <= '0;
      r_sample   <= '0;
      r_deb      <= '0;
      r_pcnt     <= '0;
      for (int i = 0; i < SyncStages; i++) r_sync[i] <= '0;
    end else begin
      // Ready pulses for exactly one cycle, and never while a response is still owed.
      r_awready <= ~r_awready & axi.awvalid & axi.wvalid & ~r_bvalid;
      r_arready <= ~r_arready & axi.arvalid & ~r_rvalid;

      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_wr_idx <= LastIdx) ? RespOkay : RespSlvErr;
      end else if (axi.bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= 32'(w_rd_val);
        r_rresp  <= (w_rd_idx <= LastIdx) ? RespOkay : RespSlvErr;
      end else if (axi.rready) begin
        r_rvalid <= 1'b0;
      end

      r_data_out <= w_data_out_next;
      if (w_we[2]) r_dir     <= (r_dir & ~w_wmask) | w_wval;
      if (w_we[3]) r_rise_en <= (r_rise_en & ~w_wmask) | w_wval;
      if (w_we[4]) r_fall_en <= (r_fall_en & ~w_wmask) | w_wval;
      if (w_we[6]) r_ie      <= (r_ie & ~w_wmask) | w_wval;
      r_status <= w_status_next;
      r_irq    <= |(r_status & r_ie);

      r_sync[0] <= gpio_i;
      for (int i = 1; i < SyncStages; i++) r_sync[i] <= r_sync[i-1];
      r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
      if (w_tick) r_sample <= w_sync;
      r_deb <= w_deb_next;
    end
  end

  assign axi.awready = r_awready;
  assign axi.wready  = r_awready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.arready = r_arready;
  assign axi.rvalid  = r_rvalid;
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;
  assign gpio_o      = r_data_out;
  assign gpio_en     = r_dir;
  assign irq         = r_irq;

  assign w_unused = ^{axi.aclk, axi.awaddr[31:6], axi.awaddr[1:0], axi.araddr[31:6],
                      axi.araddr[1:0], w_wbits, w_strb_mask};
endmodule

// File: tb/tb_axi4l_gpio_irq.sv
// Self-checking bench for axi4l_gpio_irq: register table, randomized traffic
// against a register-level model, and hand-timed debounce/reset sequences.
module tb_axi4l_gpio_irq;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int PS = 4;
  localparam logic [W-1:0] RO = 8'h03;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gpio_i, gpio_o, gpio_en;
  logic         irq;

  axi4l_if axi();
  assign axi.aclk = clk;
  always #5 clk = ~clk;

  axi4l_gpio_irq #(.Width(W), .SyncStages(SS), .Prescale(PS), .RstOut(RO)) dut (
    .clk(clk), .rst_n(rst_n), .axi(axi),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_en(gpio_en), .irq(irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aw_hs = 0;

  // Posedges since reset release, and count of accepted write handshakes.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
    if (axi.awvalid && axi.awready && axi.wvalid && axi.wready) aw_hs <= aw_hs + 1;
  end

  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status, m_ie, m_pin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called right after a negedge; returns right after a negedge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    n = 0;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    do begin @(negedge clk); n++; end while (!axi.bvalid && n < 50);
    if (!axi.bvalid) check("wr_timeout", 32'(axi.bvalid), 32'd1);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    resp = axi.bresp;
    $display("wr addr=0x%02h data=0x%08h strb=%h bresp=%0d", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
    do begin @(negedge clk); n++; end while (!axi.rvalid && n < 50);
    if (!axi.rvalid) check("rd_timeout", 32'(axi.rvalid), 32'd1);
    axi.arvalid = 1'b0;
    d = axi.rdata; resp = axi.rresp;
    $display("rd addr=0x%02h data=0x%08h rresp=%0d", a, d, resp);
  endtask

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0: return 32'(m_pin);
      1: return 32'(m_out);
      2: return 32'(m_dir);
      3: return 32'(m_rise);
      4: return 32'(m_fall);
      5: return 32'(m_status);
      6: return 32'(m_ie);
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vt[20];
  logic [31:0] rd, rd2, mask32;
  logic [1:0]  rr, rr2;
  logic [W-1:0] v, bm, newp;
  int n, c, hs0, off, kind;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
    axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
    gpio_i = '0;

    vt[0]  = '{1'b0, 32'h04, 32'h0,        4'hF, 2'b00, 32'h03, 8'h03};
    vt[1]  = '{1'b0, 32'h08, 32'h0,        4'hF, 2'b00, 32'h00, 8'h03};
    vt[2]  = '{1'b0, 32'h14, 32'h0,        4'hF, 2'b00, 32'h00, 8'h03};
    vt[3]  = '{1'b0, 32'h18, 32'h0,        4'hF, 2'b00, 32'h00, 8'h03};
    vt[4]  = '{1'b1, 32'h04, 32'hA5,       4'hF, 2'b00, 32'h00, 8'hA5};
    vt[5]  = '{1'b1, 32'h1C, 32'h0A,       4'hF, 2'b00, 32'h00, 8'hAF};
    vt[6]  = '{1'b1, 32'h20, 32'h01,       4'hF, 2'b00, 32'h00, 8'hAE};
    vt[7]  = '{1'b0, 32'h04, 32'h0,        4'hF, 2'b00, 32'hAE, 8'hAE};
    vt[8]  = '{1'b0, 32'h1C, 32'h0,        4'hF, 2'b00, 32'h00, 8'hAE};
    vt[9]  = '{1'b0, 32'h20, 32'h0,        4'hF, 2'b00, 32'h00, 8'hAE};
    vt[10] = '{1'b1, 32'h28, 32'h12345678, 4'hF, 2'b10, 32'h00, 8'hAE};
    vt[11] = '{1'b0, 32'h30, 32'h0,        4'hF, 2'b10, 32'h00, 8'hAE};
    vt[12] = '{1'b0, 32'h04, 32'h0,        4'hF, 2'b00, 32'hAE, 8'hAE};
    vt[13] = '{1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h00, 8'hAE};
    vt[14] = '{1'b0, 32'h08, 32'h0,        4'hF, 2'b00, 32'hFF, 8'hAE};
    vt[15] = '{1'b1, 32'h04, 32'h0000FF11, 4'h2, 2'b00, 32'h00, 8'hAE};
    vt[16] = '{1'b0, 32'h24, 32'h0,        4'hF, 2'b10, 32'h00, 8'hAE};
    vt[17] = '{1'b1, 32'h04, 32'h00000011, 4'h1, 2'b00, 32'h00, 8'h11};
    vt[18] = '{1'b1, 32'h04, 32'h000000FF, 4'h0, 2'b00, 32'h00, 8'h11};
    vt[19] = '{1'b0, 32'h04, 32'h0,        4'hF, 2'b00, 32'h11, 8'h11};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_gpio_en", 32'(gpio_en), 32'd0);

    for (int i = 0; i < 20; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, rr);
        check($sformatf("vec%0d_bresp", i), 32'(rr), 32'(vt[i].resp));
      end else begin
        axi_read(vt[i].addr, rd, rr);
        check($sformatf("vec%0d_rresp", i), 32'(rr), 32'(vt[i].resp));
        check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      end
      check($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(vt[i].exp_out));
    end
    check("vec_gpio_en", 32'(gpio_en), 32'hFF);

    m_out = 8'h11; m_dir = 8'hFF; m_rise = '0; m_fall = '0; m_status = '0; m_ie = '0; m_pin = '0;
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 9));
      off  = int'($urandom_range(0, 15));
      if (kind < 4) begin
        rd = $urandom;
        rr2 = 2'(off);
        mask32 = {{8{rd[31]}}, {8{rd[30]}}, {8{rd[29]}}, {8{rd[28]}}};
        rd2 = $urandom;
        bm = mask32[W-1:0];
        v = rd2[W-1:0] & bm;
        axi_write(32'(off * 4), rd2, rd[31:28], rr);
        check("rand_bresp", 32'(rr), (off <= 8) ? 32'd0 : 32'd2);
        case (off)
          1: m_out = (m_out & ~bm) | v;
          2: m_dir = (m_dir & ~bm) | v;
          3: m_rise = (m_rise & ~bm) | v;
          4: m_fall = (m_fall & ~bm) | v;
          5: m_status = m_status & ~v;
          6: m_ie = (m_ie & ~bm) | v;
          7: m_out = m_out | v;
          8: m_out = m_out & ~v;
          default: ;
        endcase
        @(negedge clk);
        check("rand_gpio_o", 32'(gpio_o), 32'(m_out));
        check("rand_gpio_en", 32'(gpio_en), 32'(m_dir));
        check("rand_irq", 32'(irq), 32'(|(m_status & m_ie)));
      end else if (kind < 8) begin
        axi_read(32'(off * 4), rd, rr);
        check("rand_rresp", 32'(rr), (off <= 8) ? 32'd0 : 32'd2);
        check($sformatf("rand_rdata_off%0d", off * 4), rd, model_read(off));
      end else begin
        newp = W'($urandom);
        gpio_i = newp;
        repeat (20) @(negedge clk);
        m_status = m_status | (newp & ~m_pin & m_rise) | (~newp & m_pin & m_fall);
        m_pin = newp;
        check("rand_pin_irq", 32'(irq), 32'(|(m_status & m_ie)));
      end
    end

    // Quiet state before the hand-timed sequences.
    axi_write(32'h0C, 32'h0, 4'hF, rr);
    axi_write(32'h10, 32'h0, 4'hF, rr);
    axi_write(32'h18, 32'h0, 4'hF, rr);
    gpio_i = '0;
    repeat (20) @(negedge clk);
    axi_write(32'h14, 32'hFF, 4'hF, rr);
    axi_write(32'h0C, 32'h1, 4'hF, rr);
    axi_write(32'h18, 32'h1, 4'hF, rr);

    // Three-cycle glitch must never see two agreeing samples.
    gpio_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_i[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_irq", 32'(irq), 32'd0);
    axi_read(32'h14, rd, rr);
    check("glitch_status", rd, 32'h0);

    gpio_i[0] = 1'b1;
    n = 0;
    while (!irq && n < SS + 9) begin @(negedge clk); n++; end
    check("edge_irq_in_time", 32'(irq), 32'd1);
    axi_read(32'h14, rd, rr);
    check("edge_status", rd, 32'h1);
    axi_read(32'h00, rd, rr);
    check("edge_in", rd, 32'h1);

    // W1C landing on the exact debounce edge: set must win.
    axi_write(32'h10, 32'h1, 4'hF, rr);
    axi_write(32'h14, 32'h1, 4'hF, rr);
    n = 0;
    while ((cyc % PS) != 1 && n < 10) begin @(negedge clk); n++; end
    c = cyc;
    gpio_i[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("align_cycle", 32'(cyc), 32'(c + 5));
    axi_write(32'h14, 32'h1, 4'hF, rr);
    axi_read(32'h14, rd, rr);
    check("w1c_vs_edge_set_wins", rd, 32'h1);

    // One cycle later the clear follows the set and must take effect.
    axi_write(32'h14, 32'h1, 4'hF, rr);
    n = 0;
    while ((cyc % PS) != 1 && n < 10) begin @(negedge clk); n++; end
    gpio_i[0] = 1'b1;
    repeat (6) @(negedge clk);
    axi_write(32'h14, 32'h1, 4'hF, rr);
    axi_read(32'h14, rd, rr);
    check("w1c_after_edge_clears", rd, 32'h0);

    // Early awvalid, stalled bready, concurrent read.
    hs0 = aw_hs;
    fork
      begin
        axi.awaddr = 32'h04; axi.awvalid = 1'b1; axi.wvalid = 1'b0; axi.bready = 1'b0;
        repeat (3) @(negedge clk);
        axi.wdata = 32'h5A; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        n = 0;
        while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
        check("stall_bvalid_seen", 32'(axi.bvalid), 32'd1);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check($sformatf("stall_bvalid_hold%0d", k), 32'(axi.bvalid), 32'd1);
        end
        check("stall_bresp", 32'(axi.bresp), 32'd0);
        axi.bready = 1'b1;
        @(negedge clk);
        check("stall_bvalid_clear", 32'(axi.bvalid), 32'd0);
        check("stall_single_accept", 32'(aw_hs - hs0), 32'd1);
      end
      begin
        axi_read(32'h00, rd2, rr2);
        check("concurrent_rdata", rd2, 32'h1);
        check("concurrent_rresp", 32'(rr2), 32'd0);
      end
    join
    check("stall_gpio_o", 32'(gpio_o), 32'h5A);

    // Reset in the middle of a write with a response still owed.
    gpio_i = '0;
    repeat (20) @(negedge clk);
    check("pre_reset_irq", 32'(irq), 32'd1);
    gpio_i = 8'h02;
    axi.awaddr = 32'h04; axi.wdata = 32'hFF; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_bvalid", 32'(axi.bvalid), 32'd1);
    rst_n = 1'b0;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    #1;
    check("in_reset_bvalid", 32'(axi.bvalid), 32'd0);
    check("in_reset_awready", 32'(axi.awready), 32'd0);
    check("in_reset_irq", 32'(irq), 32'd0);
    check("in_reset_gpio_en", 32'(gpio_en), 32'd0);
    check("in_reset_gpio_o", 32'(gpio_o), 32'(RO));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axi.bready = 1'b1;
    @(negedge clk);
    check("post_reset_bvalid", 32'(axi.bvalid), 32'd0);
    check("post_reset_irq", 32'(irq), 32'd0);
    check("post_reset_gpio_o", 32'(gpio_o), 32'(RO));
    axi_write(32'h0C, 32'h02, 4'hF, rr);
    axi_read(32'h00, rd, rr);
    check("post_reset_in_early", rd, 32'h0);
    repeat (12) @(negedge clk);
    axi_read(32'h00, rd, rr);
    check("post_reset_in_settled", rd, 32'h02);
    axi_read(32'h14, rd, rr);
    check("post_reset_rise_status", rd, 32'h02);
    axi_read(32'h04, rd, rr);
    check("post_reset_data_out", rd, 32'(RO));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
